// File: rtl/counter.sv
// Generic W-bit up-counter with clock enable and a synchronous load-to-constant.
// Wraps or saturates at all-ones; the count is driven straight from its register.
module counter #(
  parameter int W        = 8,
  parameter int SCLR_VAL = 0,
  parameter bit SATURATE = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ce,
  input  logic         sclr,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] MAX_VAL  = '1;
  localparam logic [W-1:0] LOAD_VAL = W'(SCLR_VAL);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load beats wrap/saturate; ce gates both load and increment.
  always_comb begin
    cnt_d = cnt_q;
    if (ce) begin
      if (sclr) begin
        cnt_d = LOAD_VAL;
      end else if (cnt_q == MAX_VAL) begin
        cnt_d = SATURATE ? MAX_VAL : '0;
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: tb/tb_counter.sv
// Bench for counter: three configurations share one stimulus stream and are
// checked against an arithmetic reference model plus directed expected values.
module tb_counter;

  logic       clk;
  logic       rst_n;
  logic       ce;
  logic       sclr;
  logic [3:0] cnt4w;
  logic [3:0] cnt4s;
  logic [2:0] cnt3t;

  int checks = 0;
  int errors = 0;

  // Reference model state per configuration
  int m4w = 0;
  int m4s = 0;
  int m3t = 0;

  counter #(.W(4), .SCLR_VAL(1), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .ce(ce), .sclr(sclr), .cnt(cnt4w)
  );

  counter #(.W(4), .SCLR_VAL(1), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .ce(ce), .sclr(sclr), .cnt(cnt4s)
  );

  counter #(.W(3), .SCLR_VAL(10), .SATURATE(1'b0)) dut_trunc (
    .clk(clk), .rst_n(rst_n), .ce(ce), .sclr(sclr), .cnt(cnt3t)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ref_next(int v, int w, int sv, bit sat, bit r, bit c, bit s);
    int modulus = 1 << w;
    if (!r) return 0;
    if (!c) return v;
    if (s) return sv % modulus;
    if (v == modulus - 1) return sat ? v : 0;
    return v + 1;
  endfunction

  // Driver: apply inputs away from the edge, clock once, advance the model, settle.
  task automatic step(input bit r, input bit c, input bit s);
    @(negedge clk);
    rst_n = r;
    ce    = c;
    sclr  = s;
    @(posedge clk);
    m4w = ref_next(m4w, 4, 1, 1'b0, r, c, s);
    m4s = ref_next(m4s, 4, 1, 1'b1, r, c, s);
    m3t = ref_next(m3t, 3, 10, 1'b0, r, c, s);
    #1;
  endtask

  task automatic test_reset();
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (cnt4w !== 4'd0) begin
      errors++; $display("FAIL reset_wrap got %0d want 0", cnt4w);
    end
    checks++;
    if (cnt4s !== 4'd0) begin
      errors++; $display("FAIL reset_sat got %0d want 0", cnt4s);
    end
    checks++;
    if (cnt3t !== 3'd0) begin
      errors++; $display("FAIL reset_trunc got %0d want 0", cnt3t);
    end
  endtask

  task automatic test_basic_count();
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 1'b1, 1'b0);
      checks++;
      if (cnt4w !== 4'(i)) begin
        errors++; $display("FAIL basic_count[%0d] got %0d want %0d", i, cnt4w, i);
      end
      checks++;
      if (cnt4s !== 4'(i)) begin
        errors++; $display("FAIL basic_count_sat[%0d] got %0d want %0d", i, cnt4s, i);
      end
    end
  endtask

  task automatic test_ce_stall();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b1);
      checks++;
      if (cnt4w !== 4'd5) begin
        errors++; $display("FAIL ce_stall[%0d] got %0d want 5", i, cnt4w);
      end
    end
    step(1'b1, 1'b1, 1'b0);
    checks++;
    if (cnt4w !== 4'd6) begin
      errors++; $display("FAIL ce_resume got %0d want 6", cnt4w);
    end
  endtask

  task automatic test_sclr();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
    checks++;
    if (cnt4w !== 4'd9) begin
      errors++; $display("FAIL sclr_pre got %0d want 9", cnt4w);
    end
    step(1'b1, 1'b1, 1'b1);
    checks++;
    if (cnt4w !== 4'd1) begin
      errors++; $display("FAIL sclr_load got %0d want 1", cnt4w);
    end
    checks++;
    if (cnt3t !== 3'(m3t)) begin
      errors++; $display("FAIL sclr_load_trunc got %0d want %0d", cnt3t, m3t);
    end
    for (int i = 2; i <= 3; i++) begin
      step(1'b1, 1'b1, 1'b0);
      checks++;
      if (cnt4w !== 4'(i)) begin
        errors++; $display("FAIL sclr_after[%0d] got %0d want %0d", i, cnt4w, i);
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b1);
      checks++;
      if (cnt4w !== 4'd1) begin
        errors++; $display("FAIL sclr_hold[%0d] got %0d want 1", i, cnt4w);
      end
    end
  endtask

  task automatic test_wrap_saturate();
    int exp_w[4] = '{14, 15, 0, 1};
    int exp_s[4] = '{14, 15, 15, 15};
    // Both counters sit at 1; 12 increments bring them to 13.
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b0);
      checks++;
      if (cnt4w !== 4'(exp_w[i])) begin
        errors++; $display("FAIL wrap[%0d] got %0d want %0d", i, cnt4w, exp_w[i]);
      end
      checks++;
      if (cnt4s !== 4'(exp_s[i])) begin
        errors++; $display("FAIL saturate[%0d] got %0d want %0d", i, cnt4s, exp_s[i]);
      end
    end
    // Wrap counter from 1 to 15; saturating one stays pinned.
    for (int i = 0; i < 14; i++) step(1'b1, 1'b1, 1'b0);
    checks++;
    if (cnt4w !== 4'd15 || cnt4s !== 4'd15) begin
      errors++; $display("FAIL at_max got %0d/%0d want 15/15", cnt4w, cnt4s);
    end
    step(1'b1, 1'b1, 1'b1);
    checks++;
    if (cnt4w !== 4'd1) begin
      errors++; $display("FAIL sclr_at_max_wrap got %0d want 1", cnt4w);
    end
    checks++;
    if (cnt4s !== 4'd1) begin
      errors++; $display("FAIL sclr_at_max_sat got %0d want 1", cnt4s);
    end
  endtask

  task automatic test_reset_priority();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0);
    checks++;
    if (cnt4w !== 4'd7) begin
      errors++; $display("FAIL rstprio_pre got %0d want 7", cnt4w);
    end
    step(1'b0, 1'b1, 1'b1);
    checks++;
    if (cnt4w !== 4'd0) begin
      errors++; $display("FAIL rstprio_sclr got %0d want 0", cnt4w);
    end
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (cnt4w !== 4'd0) begin
      errors++; $display("FAIL rstprio_noce got %0d want 0", cnt4w);
    end
    for (int i = 1; i <= 2; i++) begin
      step(1'b1, 1'b1, 1'b0);
      checks++;
      if (cnt4w !== 4'(i)) begin
        errors++; $display("FAIL rstprio_release[%0d] got %0d want %0d", i, cnt4w, i);
      end
    end
  endtask

  task automatic test_truncation();
    int exp_t[7] = '{2, 3, 4, 5, 6, 7, 0};
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b1, (i == 0));
      checks++;
      if (cnt3t !== 3'(exp_t[i])) begin
        errors++; $display("FAIL truncation[%0d] got %0d want %0d", i, cnt3t, exp_t[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 19) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
      checks++;
      if (cnt4w !== 4'(m4w) || cnt4s !== 4'(m4s) || cnt3t !== 3'(m3t)) begin
        errors++;
        $display("FAIL random[%0d] got %0d/%0d/%0d want %0d/%0d/%0d",
                 i, cnt4w, cnt4s, cnt3t, m4w, m4s, m3t);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ce    = 1'b0;
    sclr  = 1'b0;
    test_reset();
    test_basic_count();
    test_ce_stall();
    test_sclr();
    test_wrap_saturate();
    test_reset_priority();
    test_truncation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
